// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS core: decodes the ID instruction,
// carries its control bundle down ID/EX, EX/MEM and MEM/WB, and handles hazards.
module pipe_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter bit FWD_EN   = 1'b1,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              jump,
  output logic              jr,
  output logic              jal,
  output logic              illegal,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src_a,
  output logic              ex_alu_src_b,
  output logic              ex_alu_src_bb,
  output logic [1:0]        ex_branch,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef struct packed {
    logic [2:0]        alu_op;
    logic              src_a;
    logic              src_b;
    logic              src_bb;
    logic [1:0]        branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  idex_t  dec;
  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;

  logic legal;
  logic uses_rs;
  logic uses_rt;
  logic is_j;
  logic is_jal;
  logic is_jr;

  always_comb begin
    dec     = '0;
    dec.rs  = id_rs;
    dec.rt  = id_rt;
    dec.dst = id_rt;
    legal   = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        dec.alu_op    = 3'b010;
        dec.dst       = id_rd;
        dec.reg_write = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        case (id_func)
          F_SLL, F_SRL, F_SRA: begin
            legal     = 1'b1;
            dec.src_a = 1'b1;
            uses_rs   = 1'b0;
          end
          F_JR: begin
            legal         = 1'b1;
            dec.reg_write = 1'b0;
            is_jr         = 1'b1;
          end
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        legal          = 1'b1;
        dec.src_b      = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        uses_rs        = 1'b1;
      end
      OP_SW: begin
        legal         = 1'b1;
        dec.src_b     = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal      = 1'b1;
        dec.alu_op = 3'b001;
        dec.branch = (id_op == OP_BNE) ? 2'b10 : 2'b01;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        legal         = 1'b1;
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs       = (id_op != OP_LUI);
        dec.src_bb    = (id_op == OP_ANDI) || (id_op == OP_ORI) ||
                        (id_op == OP_XORI) || (id_op == OP_SLTIU);
        case (id_op)
          OP_ADDI: dec.alu_op = 3'b000;
          OP_ANDI: dec.alu_op = 3'b100;
          OP_ORI:  dec.alu_op = 3'b101;
          default: dec.alu_op = 3'b111;
        endcase
      end
      OP_J: begin
        legal = 1'b1;
        is_j  = 1'b1;
      end
      OP_JAL: begin
        legal         = 1'b1;
        is_jal        = 1'b1;
        dec.reg_write = 1'b1;
        dec.dst       = REG_AW'(LINK_REG);
      end
      default: legal = 1'b0;
    endcase
  end

  logic id_live;
  logic rs_used;
  logic rt_used;
  logic idex_hit;
  logic exmem_hit;
  logic load_use;
  logic jr_hazard;
  logic raw_hazard;
  logic branch_flush;
  logic redirect_ok;

  assign illegal = id_valid & ~legal;
  assign id_live = id_valid & legal;
  assign rs_used = id_live & uses_rs;
  assign rt_used = id_live & uses_rt;

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  assign idex_hit  = (idex.dst != '0) &&
                     ((rs_used && idex.dst == id_rs) || (rt_used && idex.dst == id_rt));
  assign exmem_hit = (exmem.dst != '0) &&
                     ((rs_used && exmem.dst == id_rs) || (rt_used && exmem.dst == id_rt));

  assign load_use   = idex.mem_read & idex_hit;
  assign jr_hazard  = id_live && is_jr && (id_rs != '0) &&
                      ((idex.reg_write && idex.dst == id_rs) ||
                       (exmem.mem_read && exmem.dst == id_rs));
  assign raw_hazard = !FWD_EN && ((idex.reg_write && idex_hit) ||
                                  (exmem.reg_write && exmem_hit));

  assign branch_flush = (idex.branch != 2'b00) && ex_branch_taken;
  assign stall        = !branch_flush && (load_use || jr_hazard || raw_hazard);
  assign redirect_ok  = id_live && !stall && !branch_flush;
  assign jump         = redirect_ok & is_j;
  assign jr           = redirect_ok & is_jr;
  assign jal          = redirect_ok & is_jal;
  assign flush_ifid   = branch_flush | jump | jr | jal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex <= (stall || branch_flush || !id_live) ? '0 : dec;
      exmem.mem_read   <= idex.mem_read;
      exmem.mem_write  <= idex.mem_write;
      exmem.reg_write  <= idex.reg_write;
      exmem.mem_to_reg <= idex.mem_to_reg;
      exmem.dst        <= idex.dst;
      memwb.reg_write  <= exmem.reg_write;
      memwb.mem_to_reg <= exmem.mem_to_reg;
      memwb.dst        <= exmem.dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // EX/MEM holds the newer value, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (exmem.reg_write && exmem.dst != '0 && exmem.dst == idex.rs)
        fwd_a = 2'b10;
      else if (memwb.reg_write && memwb.dst != '0 && memwb.dst == idex.rs)
        fwd_a = 2'b01;
      if (exmem.reg_write && exmem.dst != '0 && exmem.dst == idex.rt)
        fwd_b = 2'b10;
      else if (memwb.reg_write && memwb.dst != '0 && memwb.dst == idex.rt)
        fwd_b = 2'b01;
    end
  end

  assign ex_alu_op     = idex.alu_op;
  assign ex_alu_src_a  = idex.src_a;
  assign ex_alu_src_b  = idex.src_b;
  assign ex_alu_src_bb = idex.src_bb;
  assign ex_branch     = idex.branch;
  assign mem_read      = exmem.mem_read;
  assign mem_write     = exmem.mem_write;
  assign wb_reg_write  = memwb.reg_write;
  assign wb_mem_to_reg = memwb.mem_to_reg;
  assign wb_dst        = memwb.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with forwarding, one without.
// Writebacks are checked by a scoreboard; hazard strobes are checked per cycle.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       next_taken = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_op = '0;
  logic [5:0] id_func = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       ex_branch_taken = 1'b0;
  logic       a_valid;
  logic       b_valid;

  assign a_valid = id_valid & ~sel;
  assign b_valid = id_valid & sel;

  always #5 clk = ~clk;

  logic        a_stall, a_flush, a_jump, a_jr, a_jal, a_illegal;
  logic [2:0]  a_alu_op;
  logic        a_src_a, a_src_b, a_src_bb;
  logic [1:0]  a_branch, a_fwd_a, a_fwd_b;
  logic        a_mem_read, a_mem_write, a_wb_reg_write, a_wb_mem_to_reg;
  logic [4:0]  a_wb_dst;
  logic [15:0] a_stall_cnt;

  logic        b_stall, b_flush, b_jump, b_jr, b_jal, b_illegal;
  logic [2:0]  b_alu_op;
  logic        b_src_a, b_src_b, b_src_bb;
  logic [1:0]  b_branch, b_fwd_a, b_fwd_b;
  logic        b_mem_read, b_mem_write, b_wb_reg_write, b_wb_mem_to_reg;
  logic [4:0]  b_wb_dst;
  logic [15:0] b_stall_cnt;

  pipe_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b1), .LINK_REG(31), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(a_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(a_stall), .flush_ifid(a_flush), .jump(a_jump), .jr(a_jr), .jal(a_jal),
    .illegal(a_illegal), .ex_alu_op(a_alu_op), .ex_alu_src_a(a_src_a),
    .ex_alu_src_b(a_src_b), .ex_alu_src_bb(a_src_bb), .ex_branch(a_branch),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .wb_reg_write(a_wb_reg_write), .wb_mem_to_reg(a_wb_mem_to_reg),
    .wb_dst(a_wb_dst), .stall_cnt(a_stall_cnt)
  );

  pipe_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b0), .LINK_REG(31), .CNT_W(16)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(b_stall), .flush_ifid(b_flush), .jump(b_jump), .jr(b_jr), .jal(b_jal),
    .illegal(b_illegal), .ex_alu_op(b_alu_op), .ex_alu_src_a(b_src_a),
    .ex_alu_src_b(b_src_b), .ex_alu_src_bb(b_src_bb), .ex_branch(b_branch),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .wb_reg_write(b_wb_reg_write), .wb_mem_to_reg(b_wb_mem_to_reg),
    .wb_dst(b_wb_dst), .stall_cnt(b_stall_cnt)
  );

  typedef struct {
    logic [4:0] dst;
    int         edge_no;
  } wb_exp_t;

  wb_exp_t q_a[$];
  wb_exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every register write leaving WB must match the oldest expected retirement.
  always @(negedge clk) begin : monitor_a
    wb_exp_t e;
    if (a_wb_reg_write === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wb_a_unexpected: got write to %0d expected none", a_wb_dst);
      end else begin
        e = q_a.pop_front();
        checkOutput("wb_a_dst", 32'(a_wb_dst), 32'(e.dst));
        checkOutput("wb_a_edge", edge_cnt, e.edge_no);
      end
    end
  end

  always @(negedge clk) begin : monitor_b
    wb_exp_t e;
    if (b_wb_reg_write === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wb_b_unexpected: got write to %0d expected none", b_wb_dst);
      end else begin
        e = q_b.pop_front();
        checkOutput("wb_b_dst", 32'(b_wb_dst), 32'(e.dst));
        checkOutput("wb_b_edge", edge_cnt, e.edge_no);
      end
    end
  end

  task automatic setInputs(input logic v, input logic [5:0] op, input logic [5:0] func,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid        = v;
    id_op           = op;
    id_func         = func;
    id_rs           = rs;
    id_rt           = rt;
    id_rd           = rd;
    ex_branch_taken = next_taken;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] func,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    @(posedge clk);
    #1;
    setInputs(v, op, func, rs, rt, rd);
    @(negedge clk);
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  // Instruction leaves ID on the next edge and retires in WB two edges later.
  task automatic expectA(input logic [4:0] dst);
    q_a.push_back('{dst: dst, edge_no: edge_cnt + 3});
  endtask

  task automatic expectB(input logic [4:0] dst);
    q_b.push_back('{dst: dst, edge_no: edge_cnt + 3});
  endtask

  initial begin
    @(negedge clk);
    checkOutput("rst_stall_cnt", 32'(a_stall_cnt), 0);
    checkOutput("rst_wb_reg_write", 32'(a_wb_reg_write), 0);
    checkOutput("rst_ex_alu_op", 32'(a_alu_op), 0);
    checkOutput("rst_mem_read", 32'(a_mem_read), 0);
    checkOutput("rst_nofwd_stall_cnt", 32'(b_stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add $3,$1,$2 with empty pipeline
    applyStimulus(1, OP_R, F_ADD, 1, 2, 3); expectA(3);
    checkOutput("add_stall", 32'(a_stall), 0);
    checkOutput("add_illegal", 32'(a_illegal), 0);
    bubble();
    checkOutput("add_ex_alu_op", 32'(a_alu_op), 32'b010);
    bubble(); bubble();

    // load-use: lw $5 then add $6,$5,$2
    applyStimulus(1, OP_LW, 0, 1, 5, 0); expectA(5);
    checkOutput("lw_stall", 32'(a_stall), 0);
    applyStimulus(1, OP_R, F_ADD, 5, 2, 6);
    checkOutput("lu_stall", 32'(a_stall), 1);
    checkOutput("lu_flush", 32'(a_flush), 0);
    checkOutput("lu_ex_src_b", 32'(a_src_b), 1);
    applyStimulus(1, OP_R, F_ADD, 5, 2, 6); expectA(6);
    checkOutput("lu_release", 32'(a_stall), 0);
    checkOutput("lu_mem_read", 32'(a_mem_read), 1);
    checkOutput("lu_stall_cnt", 32'(a_stall_cnt), 1);
    bubble();
    checkOutput("lu_fwd_a", 32'(a_fwd_a), 32'b01);
    checkOutput("lu_fwd_b", 32'(a_fwd_b), 32'b00);
    checkOutput("lu_wb_mem_to_reg", 32'(a_wb_mem_to_reg), 1);
    bubble(); bubble();

    // forward priority on $4
    applyStimulus(1, OP_ADDI, 0, 0, 4, 0); expectA(4);
    applyStimulus(1, OP_ADDI, 0, 4, 4, 0); expectA(4);
    checkOutput("fp_addi_stall", 32'(a_stall), 0);
    applyStimulus(1, OP_R, F_ADD, 4, 4, 7); expectA(7);
    checkOutput("fp_add_stall", 32'(a_stall), 0);
    checkOutput("fp_addi_fwd_a", 32'(a_fwd_a), 32'b10);
    bubble();
    checkOutput("fp_fwd_a", 32'(a_fwd_a), 32'b10);
    checkOutput("fp_fwd_b", 32'(a_fwd_b), 32'b10);
    bubble(); bubble();
    applyStimulus(1, OP_ADDI, 0, 0, 0, 0); expectA(0);
    applyStimulus(1, OP_R, F_ADD, 0, 0, 7); expectA(7);
    bubble();
    checkOutput("zero_fwd_a", 32'(a_fwd_a), 32'b00);
    checkOutput("zero_fwd_b", 32'(a_fwd_b), 32'b00);
    bubble(); bubble();

    // taken beq in EX overrides pending jr hazard in ID
    applyStimulus(1, OP_LW, 0, 1, 31, 0); expectA(31);
    applyStimulus(1, OP_BEQ, 0, 1, 2, 0);
    checkOutput("beq_stall", 32'(a_stall), 0);
    next_taken = 1'b1;
    applyStimulus(1, OP_R, F_JR, 31, 0, 0);
    checkOutput("br_flush", 32'(a_flush), 1);
    checkOutput("br_stall", 32'(a_stall), 0);
    checkOutput("br_jr", 32'(a_jr), 0);
    checkOutput("br_ex_branch", 32'(a_branch), 32'b01);
    next_taken = 1'b0;
    bubble();
    checkOutput("br_bubble_alu_op", 32'(a_alu_op), 32'b000);
    checkOutput("br_bubble_branch", 32'(a_branch), 32'b00);
    checkOutput("br_flush_clear", 32'(a_flush), 0);
    checkOutput("br_stall_cnt", 32'(a_stall_cnt), 1);
    bubble();

    // jal and j
    applyStimulus(1, OP_JAL, 0, 0, 0, 0); expectA(31);
    checkOutput("jal_strobe", 32'(a_jal), 1);
    checkOutput("jal_flush", 32'(a_flush), 1);
    checkOutput("jal_jump", 32'(a_jump), 0);
    bubble();
    checkOutput("jal_strobe_end", 32'(a_jal), 0);
    checkOutput("jal_flush_end", 32'(a_flush), 0);
    bubble(); bubble();
    applyStimulus(1, OP_J, 0, 0, 0, 0);
    checkOutput("j_strobe", 32'(a_jump), 1);
    checkOutput("j_flush", 32'(a_flush), 1);
    bubble();

    // jr $31 with lw $31 one slot ahead
    applyStimulus(1, OP_LW, 0, 1, 31, 0); expectA(31);
    bubble();
    applyStimulus(1, OP_R, F_JR, 31, 0, 0);
    checkOutput("jr_stall", 32'(a_stall), 1);
    checkOutput("jr_held", 32'(a_jr), 0);
    checkOutput("jr_held_flush", 32'(a_flush), 0);
    applyStimulus(1, OP_R, F_JR, 31, 0, 0);
    checkOutput("jr_go_stall", 32'(a_stall), 0);
    checkOutput("jr_strobe", 32'(a_jr), 1);
    checkOutput("jr_flush", 32'(a_flush), 1);
    checkOutput("jr_stall_cnt", 32'(a_stall_cnt), 2);
    bubble();
    checkOutput("jr_strobe_end", 32'(a_jr), 0);
    bubble();

    // reset in the middle of a load-use stall
    applyStimulus(1, OP_LW, 0, 1, 8, 0);
    applyStimulus(1, OP_R, F_ADD, 8, 8, 9);
    checkOutput("pre_rst_stall", 32'(a_stall), 1);
    #1;
    q_a.delete();
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall_cnt", 32'(a_stall_cnt), 0);
    checkOutput("midrst_stall", 32'(a_stall), 0);
    checkOutput("midrst_ex_src_b", 32'(a_src_b), 0);
    checkOutput("midrst_mem_read", 32'(a_mem_read), 0);
    checkOutput("midrst_wb_reg_write", 32'(a_wb_reg_write), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    setInputs(1, OP_R, F_ADD, 1, 2, 3);
    @(negedge clk);
    expectA(3);
    checkOutput("postrst_stall", 32'(a_stall), 0);
    bubble(); bubble(); bubble();

    // no-forwarding instance
    sel = 1'b1;
    applyStimulus(1, OP_R, F_ADD, 1, 2, 3); expectB(3);
    checkOutput("nf_first_stall", 32'(b_stall), 0);
    applyStimulus(1, OP_R, F_ADD, 3, 2, 6);
    checkOutput("nf_stall_exdep", 32'(b_stall), 1);
    applyStimulus(1, OP_R, F_ADD, 3, 2, 6);
    checkOutput("nf_stall_memdep", 32'(b_stall), 1);
    applyStimulus(1, OP_R, F_ADD, 3, 2, 6); expectB(6);
    checkOutput("nf_release", 32'(b_stall), 0);
    checkOutput("nf_stall_cnt", 32'(b_stall_cnt), 2);
    bubble(); bubble(); bubble();
    applyStimulus(1, OP_ADDI, 0, 0, 3, 0); expectB(3);
    applyStimulus(1, OP_R, F_SLL, 3, 2, 9); expectB(9);
    checkOutput("nf_sll_stall", 32'(b_stall), 0);
    bubble();
    checkOutput("nf_fwd_a_forced", 32'(b_fwd_a), 32'b00);
    checkOutput("nf_sll_src_a", 32'(b_src_a), 1);
    bubble(); bubble();
    applyStimulus(1, 6'b111111, 0, 1, 2, 3);
    checkOutput("illegal_op", 32'(b_illegal), 1);
    checkOutput("illegal_stall", 32'(b_stall), 0);
    applyStimulus(1, OP_R, 6'h01, 1, 2, 3);
    checkOutput("illegal_func", 32'(b_illegal), 1);
    bubble();
    checkOutput("illegal_clear", 32'(b_illegal), 0);
    bubble(); bubble(); bubble();

    checkOutput("q_a_drained", q_a.size(), 0);
    checkOutput("q_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
